rtc_bus_sched: RTL

RTC_BUS_SCHED -- requirements
Module: rtc_bus_sched

---
 rtl/rtc_bus_sched.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/rtc_bus_sched.sv
// rtc_bus_sched: schedules RTC edit writes (date, time, timer) and periodic refresh
// reads onto a single bus-cycle engine, one command at a time.
//
// Handshake: req_* is a level that the requester holds until its ack bit pulses for
// one cycle. start is a one-cycle command strobe. cyc_addr/cyc_wr/cyc_wdata are valid
// from start until the engine's one-cycle cyc_done. cyc_done is honoured only in WAIT.
module rtc_bus_sched #(
    parameter int REFRESH_CYCLES = 50000,
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_date,
    input  logic        req_time,
    input  logic        req_timer,
    input  logic [23:0] wr_date,
    input  logic [23:0] wr_time,
    input  logic [23:0] wr_timer,
    output logic [2:0]  ack,
    output logic        start,
    output logic [7:0]  cyc_addr,
    output logic        cyc_wr,
    output logic [7:0]  cyc_wdata,
    input  logic        cyc_done,
    input  logic [7:0]  cyc_rdata,
    output logic        rd_valid,
    output logic [2:0]  rd_index,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic [1:0]  grant,
    output logic        timeout_err,
    output logic [2:0]  dbg_state
);

    localparam int RW = $clog2(REFRESH_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_owner;      // 1 date, 2 time, 3 timer or refresh
    logic          r_refresh;
    logic [23:0]   r_data;
    logic [2:0]    r_step;
    logic [TW-1:0] r_wait_cnt;
    logic [RW-1:0] r_ref_cnt;
    logic          r_ref_pend;
    logic [1:0]    r_rr_ptr;     // first requester to consider: 0 date, 1 time, 2 timer
    logic [7:0]    r_rdata;

    logic [2:0]    w_req;
    logic          w_edit_hit;
    logic [1:0]    w_pick;
    logic [2:0]    w_sum;
    logic [1:0]    w_k;
    logic [23:0]   w_pick_data;
    logic          w_timeout;
    logic          w_last_step;
    logic          w_cmd_valid;
    logic [7:0]    w_base;
    logic          w_ref_wrap;

    assign w_req       = {req_timer, req_time, req_date};
    assign w_timeout   = (r_state == WAIT) && !cyc_done && (r_wait_cnt == TMO_LAST);
    assign w_last_step = r_refresh ? (r_step == 3'd5) : (r_step == 3'd4);
    assign w_cmd_valid = (r_state == ISSUE) || (r_state == WAIT);
    assign w_ref_wrap  = (r_ref_cnt == REF_LAST);

    // Round-robin pick among asserted edit requests, starting at r_rr_ptr.
    always_comb begin
        w_edit_hit = 1'b0;
        w_pick     = 2'd0;
        w_sum      = 3'd0;
        w_k        = 2'd0;
        for (int i = 0; i < 3; i++) begin
            w_sum = {1'b0, r_rr_ptr} + 3'(i);
            w_k   = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
            if (!w_edit_hit && w_req[w_k]) begin
                w_edit_hit = 1'b1;
                w_pick     = w_k;
            end
        end
        case (w_pick)
            2'd0:    w_pick_data = wr_date;
            2'd1:    w_pick_data = wr_time;
            default: w_pick_data = wr_timer;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_edit_hit || r_ref_pend) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT: begin
                if (cyc_done)       w_next = STEP;
                else if (w_timeout) w_next = IDLE;
            end
            STEP:    w_next = w_last_step ? DONE : ISSUE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Transaction context, step/timeout counters, refresh timer and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= 2'd0;
            r_refresh  <= 1'b0;
            r_data     <= 24'd0;
            r_step     <= 3'd0;
            r_wait_cnt <= '0;
            r_ref_cnt  <= '0;
            r_ref_pend <= 1'b0;
            r_rr_ptr   <= 2'd0;
            r_rdata    <= 8'd0;
        end else begin
            // A wrap while already pending simply re-sets the same flag.
            if (r_state == DONE && r_refresh) r_ref_pend <= 1'b0;
            if (w_ref_wrap) begin
                r_ref_cnt  <= '0;
                r_ref_pend <= 1'b1;
            end else begin
                r_ref_cnt <= r_ref_cnt + RW'(1);
            end

            case (r_state)
                IDLE: begin
                    r_step <= 3'd0;
                    if (w_edit_hit) begin
                        // The pointer moves at grant, so an aborted requester is also passed over.
                        r_owner   <= w_pick + 2'd1;
                        r_refresh <= 1'b0;
                        r_data    <= w_pick_data;
                        r_rr_ptr  <= (w_pick == 2'd2) ? 2'd0 : w_pick + 2'd1;
                    end else if (r_ref_pend) begin
                        r_owner   <= 2'd3;
                        r_refresh <= 1'b1;
                    end
                end
                ISSUE: r_wait_cnt <= '0;
                WAIT: begin
                    if (cyc_done) r_rdata    <= cyc_rdata;
                    else          r_wait_cnt <= r_wait_cnt + TW'(1);
                end
                STEP:    r_step <= r_step + 3'd1;
                default: ;
            endcase
        end
    end

    // Bus command for the current step, held from ISSUE through WAIT.
    always_comb begin
        case (r_owner)
            2'd1:    w_base = 8'h24;
            2'd2:    w_base = 8'h21;
            default: w_base = 8'h41;
        endcase
        cyc_addr  = 8'h00;
        cyc_wr    = 1'b0;
        cyc_wdata = 8'h00;
        if (w_cmd_valid) begin
            if (r_refresh) begin
                cyc_addr = 8'h21 + {5'd0, r_step};
            end else begin
                cyc_wr = 1'b1;
                case (r_step)
                    3'd0: begin cyc_addr = 8'h02;          cyc_wdata = 8'h10;         end
                    3'd1: begin cyc_addr = w_base;         cyc_wdata = r_data[7:0];   end
                    3'd2: begin cyc_addr = w_base + 8'd1;  cyc_wdata = r_data[15:8];  end
                    3'd3: begin cyc_addr = w_base + 8'd2;  cyc_wdata = r_data[23:16]; end
                    default: begin cyc_addr = 8'h02;       cyc_wdata = 8'h00;         end
                endcase
            end
        end
    end

    // Status, completion and refresh-read outputs.
    always_comb begin
        busy        = (r_state != IDLE);
        grant       = busy ? r_owner : 2'd0;
        start       = (r_state == ISSUE);
        timeout_err = w_timeout;
        dbg_state   = r_state;
        rd_valid    = (r_state == STEP) && r_refresh;
        rd_index    = rd_valid ? r_step : 3'd0;
        rd_data     = rd_valid ? r_rdata : 8'd0;
        ack         = 3'b000;
        if (r_state == DONE && !r_refresh) begin
            case (r_owner)
                2'd1:    ack = 3'b001;
                2'd2:    ack = 3'b010;
                default: ack = 3'b100;
            endcase
        end
    end

endmodule
